// File: rtl/vote_seq_pkg.sv
// vote_seq_pkg: shared types and constants for the three-voter ballot sequencer.
// Contents: FSM state enum, voter/counter sizing, seven-segment glyphs and a
// helper that maps the set of voters already counted to its digit glyph.
package vote_seq_pkg;
    typedef enum logic [1:0] {COLLECT, EVAL, SHOW} state_t;
    localparam int NUM_VOTERS = 3;
    localparam int CNT_W = 4;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_P = 7'h73;
    localparam logic [6:0] SEG_F = 7'h71;
    function automatic logic [6:0] count_seg(input logic [NUM_VOTERS-1:0] v);
        logic [1:0] n;
        n = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
        return n == 2'd0 ? SEG_0 : n == 2'd1 ? SEG_1 : n == 2'd2 ? SEG_2 : SEG_3;
    endfunction
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: combinational three-way round-robin arbiter.
// Ports: pend = pending requests, ptr = highest-priority voter this cycle,
// en = allow a grant; gnt = one-hot grant, next_ptr = voter after the granted one
// (ptr unchanged when nothing is granted).
module rr_arb3
    import vote_seq_pkg::*;
(
    input  logic [NUM_VOTERS-1:0] pend,
    input  logic [1:0]            ptr,
    input  logic                  en,
    output logic [NUM_VOTERS-1:0] gnt,
    output logic [1:0]            next_ptr
);
    logic [NUM_VOTERS-1:0] rot;
    logic [NUM_VOTERS-1:0] rot_gnt;
    // Rotate so rot[0] is the voter at ptr, pick the lowest set bit, rotate back.
    always_comb begin
        rot      = ptr == 2'd1 ? {pend[0], pend[2:1]} : ptr == 2'd2 ? {pend[1:0], pend[2]} : pend;
        rot_gnt  = !en ? 3'b000 : rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
        gnt      = ptr == 2'd1 ? {rot_gnt[1:0], rot_gnt[2]} : ptr == 2'd2 ? {rot_gnt[0], rot_gnt[2:1]} : rot_gnt;
        next_ptr = gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : gnt[2] ? 2'd0 : ptr;
    end
endmodule

// File: rtl/tt_um_nlp52_vote_sequencer.sv
// tt_um_nlp52_vote_sequencer: three-voter 2-of-3 ballot sequencer TinyTapeout tile.
// Ports: ui_in[2:0] request buttons, ui_in[5:3] votes, ui_in[6] clear;
// uo_out[6:0] seven-segment (a=bit0), uo_out[7] showing verdict;
// uio_out = {fail_cnt, pass_cnt}; uio_oe all outputs; uio_in, ena, ui_in[7] unused.
module tt_um_nlp52_vote_sequencer
    import vote_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    logic [7:0]            sync_q [SYNC_STAGES];
    logic [7:0]            ui_s;
    logic [NUM_VOTERS-1:0] req_s, vote_s, req_d, rise;
    logic                  clr_s;
    logic [NUM_VOTERS-1:0] pend, voted, ballot, gnt;
    logic [1:0]            ptr, next_ptr;
    logic [CNT_W-1:0]      pass_cnt, fail_cnt;
    logic                  last_result, result;
    state_t                state, state_n;
    logic                  collect, do_eval, restart;
    logic                  unused;

    assign ui_s    = sync_q[SYNC_STAGES-1];
    assign req_s   = ui_s[2:0];
    assign vote_s  = ui_s[5:3];
    assign clr_s   = ui_s[6];
    assign rise    = req_s & ~req_d;
    assign result  = (ballot[0] | ballot[1]) & ballot[2] | (ballot[0] & ballot[1]);
    assign uio_out = {fail_cnt, pass_cnt};
    assign uio_oe  = 8'hFF;
    assign unused  = &{1'b0, uio_in, ena, ui_s[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= ui_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    rr_arb3 u_arb (
        .pend     (pend),
        .ptr      (ptr),
        .en       (collect && !clr_s),
        .gnt      (gnt),
        .next_ptr (next_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_n;
    end

    // Clear outranks every other transition; leaving SHOW needs all buttons released.
    always_comb begin
        collect = state == COLLECT;
        do_eval = state == EVAL && !clr_s;
        restart = clr_s || (state == SHOW && req_s == '0);
        state_n = clr_s ? COLLECT
                : collect && &voted ? EVAL
                : state == EVAL ? SHOW
                : restart ? COLLECT
                : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d       <= '0;
            pend        <= '0;
            voted       <= '0;
            ballot      <= '0;
            ptr         <= 2'd0;
            last_result <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            uo_out      <= {1'b0, SEG_0};
        end else begin
            req_d       <= req_s;
            // Presses outside COLLECT or from voters already counted are dropped.
            pend        <= restart ? '0 : (pend | (rise & ~voted & {NUM_VOTERS{collect}})) & ~gnt;
            voted       <= restart ? '0 : voted | gnt;
            ballot      <= restart ? '0 : (ballot & ~gnt) | (vote_s & gnt);
            ptr         <= next_ptr;
            last_result <= do_eval ? result : last_result;
            pass_cnt    <= clr_s ? '0 : do_eval && result && !(&pass_cnt) ? pass_cnt + 1'b1 : pass_cnt;
            fail_cnt    <= clr_s ? '0 : do_eval && !result && !(&fail_cnt) ? fail_cnt + 1'b1 : fail_cnt;
            uo_out      <= state == EVAL ? uo_out
                         : state == SHOW ? {1'b1, last_result ? SEG_P : SEG_F}
                         : {1'b0, count_seg(voted)};
        end
    end
endmodule

// File: doc/tt_um_nlp52_vote_sequencer.md
# tt_um_nlp52_vote_sequencer

Three-voter ballot sequencer for the 2-of-3 pair/triple detection function, packaged as a TinyTapeout user tile. It synchronizes three voter request buttons and uses a round-robin arbiter to latch one ballot per cycle. Once all three ballots are in, it evaluates the 2-of-3 result, keeps saturating pass/fail tallies, and drives the seven-segment display and the tally pins.

## Interface
- SYNC_STAGES, 2: synchronizer depth on all ui_in bits (min 2).
- clk  in  1  tile clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ui_in  in  8  [2:0] request button per voter (level); [5:3] vote value per voter (bit 3+i belongs to voter i); [6] clear tallies and abort round; [7] unused.
- uo_out  out  8  [6:0] seven-segment, active high, a=bit0 to g=bit6; [7] high while in SHOW.
- uio_in  in  8  unused.
- uio_out  out  8  [3:0] pass_cnt, [7:4] fail_cnt.
- uio_oe  out  8  constant 8'hFF.
- ena  in  1  ignored.

## Operation
- Synchronization: every ui_in bit passes through SYNC_STAGES flops, giving req_s, vote_s and clr_s. A further delay flop on req_s supplies rise[i] = req_s[i] & ~req_d[i].
- Pending flags:
  - pend[i] sets on rise[i] only when voted[i]=0 and state=COLLECT; otherwise the rise is discarded.
  - pend[i] clears on grant to voter i.
- Arbiter:
  - Each cycle in COLLECT, at most one grant goes to the first pending voter found in the order ptr, ptr+1, ptr+2 (mod 3).
  - On grant i: ballot[i] <= vote_s[i] at the grant edge, voted[i] <= 1, ptr <= (i+1) mod 3.
- FSM states and transitions:
  - COLLECT to EVAL when voted==3'b111.
  - EVAL lasts exactly 1 cycle. At its end: result = (b0|b1)&b2 | (b0&b1); last_result <= result; if result=1, pass_cnt increments, else fail_cnt increments. Counters are 4-bit and saturate at 15. Then go to SHOW.
  - SHOW holds while any req_s bit is high. When all are low: voted, pend and ballot are cleared and the FSM returns to COLLECT.
  - Minimum SHOW time is 1 cycle.
- Clear:
  - clr_s=1 zeroes both counters, voted, pend and ballot, and forces COLLECT; ptr is kept.
  - Clear has priority over a grant or an EVAL update in the same cycle.
- Display:
  - COLLECT shows popcount(voted) as 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F.
  - EVAL shows the previous uo_out value.
  - SHOW shows P=0x73 when last_result=1, F=0x71 when 0.
- All outputs are registered.

## Timing
- Reset values: state COLLECT, ptr=0, all flags, ballots and counters 0; uo_out=8'h3F; uio_out=8'h00; uio_oe=8'hFF.
- Request latency, with SYNC_STAGES=2 and no contention:
  - ui_in[i] is first sampled high at edge k.
  - req_s is high after edge k+1.
  - pend is set at edge k+2.
  - ballot is latched at edge k+3.
  - The display digit updates after edge k+4.
- Simultaneous rises are all pended and granted on consecutive edges in round-robin order.
- Third ballot latched at edge t: EVAL from t+1, counters and SHOW from t+2, COLLECT no earlier than t+3.
- Held buttons do not re-vote: a press is an edge, and SHOW waits for release.
- A rise during EVAL or SHOW is dropped and never pended.
- rst_n low at any point, including mid-round, clears everything asynchronously. The first edge after deassertion behaves as from reset.

## Structure
- Package vote_seq_pkg holds:
  - the state enum (COLLECT, EVAL, SHOW);
  - NUM_VOTERS=3 and CNT_W=4;
  - the segment constants SEG_0..SEG_3, SEG_P, SEG_F.
- Sub-module rr_arb3:
  - inputs: pend[2:0], ptr[1:0], en;
  - outputs: one-hot gnt[2:0] and next_ptr;
  - combinational.
- The 2-of-3 evaluation and the counters stay inline in the top.

## Test plan
- Reset then idle: uo_out=0x3F, uio_out=0x00, uio_oe=0xFF. Pulse voters 0, 1, 2 sequentially with votes 1,1,0: display steps 1→2→3, then 0x73 and uo_out[7]=1; uio_out=0x01; release all → 0x3F.
- All three requests rise in the same cycle with votes 0,0,1 and ptr=0: grants go to 0, 1, 2 on consecutive edges; result F=0x71; uio_out=0x10.
- Voter 1 presses twice before round completion with vote changed between presses: only the first-granted vote counts, and the second press has no effect on voted or display.
- Sixteen pass rounds, then one more: pass_cnt saturates at 4'hF (uio_out[3:0]=0xF). Assert clear: uio_out=0x00 after sync latency, display 0x3F.
- Two ballots latched, then rst_n pulsed low mid-cycle: all outputs return immediately to reset values. Next round requires three fresh ballots.
- Clear asserted in the same cycle as the third grant: ballot discarded, no counter change, display 0x3F.
